q_learn_sequencer: RTL
======================

Name: q_learn_sequencer

Overview:
Episode/step controller for the Q-learning datapath. Per step it reads the 37x4 Q table to pick an action (epsilon-greedy via LFSR), hands the action to the maze environment, scans the next state's Q row for max_Q, then launches and waits on the Q-update block. It loops until the goal or a step limit is reached. It sits between the maze environment, the Q table read port and the Q-update block.

Parameters:
NUM_STATES, 37, valid states 0..NUM_STATES-1
NUM_ACTIONS, 4, actions per state (fixed 4; action field 4 bits)
MAX_STEPS, 255, step limit per episode (1..255)
EPSILON, 8'd26, explore when lfsr[7:0] < EPSILON (~10%)
LFSR_SEED, 16'hACE1, reset value of LFSR, must be nonzero

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; begin episode (ignored while busy)
start_state  in  6  episode start state, sampled with start
goal_state  in  6  terminal state, sampled with start
q_rd_state  out  6  Q table read state index
q_rd_action  out  4  Q table read action index
q_rd_data  in  32  Q15.16 signed, combinational read of [q_rd_state][q_rd_action]
env_req  out  1  action request to environment
env_state  out  6  current state
env_action  out  4  chosen action
env_ack  in  1  environment response valid
env_next_state  in  6  resulting state
env_reward  in  4  reward (unsigned integer)
upd_go  out  1  update request, level
upd_state  out  6  update state index
upd_action  out  4  update action
upd_max_q  out  32  max Q of next state
upd_reward  out  4  reward
upd_done  in  1  update complete
busy  out  1  episode in progress
episode_done  out  1  one-cycle pulse at episode end
step_count  out  8  steps completed this episode
error  out  1  sticky; env_next_state >= NUM_STATES; cleared by next start

Behaviour:
- Reset: all outputs 0, all registers 0, LFSR = LFSR_SEED, FSM = IDLE. Async assert aborts any operation and drops env_req and upd_go immediately.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle the FSM is not IDLE.
- IDLE: on start, latch cur = start_state and goal, clear step_count and error, set busy=1, go SEL. If start_state == goal_state: busy for one cycle, then episode_done pulse with step_count 0.
- SEL (4 cycles): q_rd_state=cur, q_rd_action=0..3, one per cycle. Track argmax by signed compare; ties keep the lower index.
  - On the cycle after the scan, the LFSR value in that cycle decides the action: if lfsr[7:0] < EPSILON, action = lfsr[9:8]; else argmax. Go ENV.
- ENV: env_req=1 with env_state=cur and env_action held stable. On the first cycle env_ack=1:
  - latch next_state and reward;
  - env_req deasserts the next cycle;
  - if next_state >= NUM_STATES: set error, pulse episode_done, go IDLE with no update;
  - else go MAX.
- MAX (4 cycles): scan row next_state for signed max into upd_max_q.
- UPD: upd_go=1 with upd_state=cur, upd_action=action, upd_max_q, upd_reward. All upd_* outputs stay stable while upd_go=1. On the first cycle upd_done=1, upd_go drops the next cycle and step_count increments.
- ADV: if next_state == goal or step_count == MAX_STEPS: pulse episode_done, busy=0, go IDLE. Otherwise cur = next_state, go SEL.
- Step latency with zero-wait handshakes: 4 (SEL) + 1 (decide) + 1 (ENV) + 4 (MAX) + 1 (UPD) + 1 (ADV) = 12 cycles.
- The SEL scan after an update sees the already-updated table; no read bypass is needed.
- start while busy is ignored. env_ack outside ENV and upd_done outside UPD are ignored.
- step_count holds its value after episode_done until the next start.

Test Plan:
- Greedy path: EPSILON=0, all Q=0 except Q[0][2]=0x00010000; start_state=0, goal=1; env maps (0,2)->1, reward 10. Expect env_action=2, one upd_go with upd_state=0, upd_action=2, upd_max_q=0, upd_reward=10. Expect episode_done 12 cycles after start+1, step_count=1.
- Tie/negative: row = {0xFFFF0000, 0xFFFF0000, 0xFFFE0000, 0xFFFF8000}, EPSILON=0. Expect action 3 (-0.5 beats -1).
- Step limit: MAX_STEPS=3, env never reaches goal. Expect exactly 3 upd_go handshakes, then episode_done with step_count=3.
- Handshake stall: env_ack delayed 5 cycles, upd_done delayed 7 cycles. Expect env_req and upd_go held with stable payloads and no double counting; step latency = 12+5+7 cycles.
- Error/reset: env returns next_state=40. Expect error=1, episode_done, no upd_go. Then assert rst during UPD: all outputs 0 asynchronously, and a fresh start works.
- Exploration: EPSILON=255 from reset seed. Expect env_action to equal lfsr[9:8] of the decide cycle, checked against a reference LFSR model over 20 steps.

Source files
------------

// File: rtl/q_learn_sequencer.sv
// Episode/step controller for the Q-learning datapath: greedy/explore action pick,
// environment handshake, next-state max_Q scan and Q-update launch, looped per step.
module q_learn_sequencer #(
  parameter int          NUM_STATES  = 37,
  parameter int          NUM_ACTIONS = 4,
  parameter int          MAX_STEPS   = 255,
  parameter logic [7:0]  EPSILON     = 8'd26,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  start_state,
  input  logic [5:0]  goal_state,
  output logic [5:0]  q_rd_state,
  output logic [3:0]  q_rd_action,
  input  logic [31:0] q_rd_data,
  output logic        env_req,
  output logic [5:0]  env_state,
  output logic [3:0]  env_action,
  input  logic        env_ack,
  input  logic [5:0]  env_next_state,
  input  logic [3:0]  env_reward,
  output logic        upd_go,
  output logic [5:0]  upd_state,
  output logic [3:0]  upd_action,
  output logic [31:0] upd_max_q,
  output logic [3:0]  upd_reward,
  input  logic        upd_done,
  output logic        busy,
  output logic        episode_done,
  output logic [7:0]  step_count,
  output logic        error,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEL  = 3'd1,
    S_DEC  = 3'd2,
    S_ENV  = 3'd3,
    S_MAX  = 3'd4,
    S_UPD  = 3'd5,
    S_ADV  = 3'd6
  } state_t;

  localparam logic [1:0] LAST_IDX = 2'(NUM_ACTIONS - 1);
  localparam logic [6:0] NS_LIM   = 7'(NUM_STATES);
  localparam logic [7:0] STEP_LIM = 8'(MAX_STEPS);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [5:0]         r_cur;
  logic [5:0]         r_goal;
  logic [5:0]         r_next;
  logic [3:0]         r_reward;
  logic [1:0]         r_action;
  logic [1:0]         r_idx;
  logic [1:0]         r_best_a;
  logic signed [31:0] r_best;
  logic [15:0]        r_lfsr;
  logic               r_busy;
  logic               r_done;
  logic [7:0]         r_steps;
  logic               r_error;

  logic signed [31:0] w_q;
  logic               w_scan_last;
  logic               w_bad_next;
  logic               w_at_end;
  logic               w_explore;
  logic               w_fb;

  assign w_q         = q_rd_data;
  assign w_scan_last = (r_idx == LAST_IDX);
  assign w_bad_next  = ({1'b0, env_next_state} >= NS_LIM);
  assign w_at_end    = (r_next == r_goal) || (r_steps == STEP_LIM);
  assign w_explore   = (r_lfsr[7:0] < EPSILON);
  assign w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Handshakes: env_req / upd_go are levels held with a stable payload until the
  // first cycle the partner answers (env_ack / upd_done); that cycle completes the
  // transfer and the request drops on the next cycle. Answers in other states are ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = (start_state == goal_state) ? S_ADV : S_SEL;
      S_SEL:  if (w_scan_last) w_state_nxt = S_DEC;
      S_DEC:  w_state_nxt = S_ENV;
      S_ENV:  if (env_ack) w_state_nxt = w_bad_next ? S_IDLE : S_MAX;
      S_MAX:  if (w_scan_last) w_state_nxt = S_UPD;
      S_UPD:  if (upd_done) w_state_nxt = S_ADV;
      S_ADV:  w_state_nxt = w_at_end ? S_IDLE : S_SEL;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur    <= '0;
      r_goal   <= '0;
      r_next   <= '0;
      r_reward <= '0;
      r_action <= '0;
      r_idx    <= '0;
      r_best_a <= '0;
      r_best   <= '0;
      r_lfsr   <= LFSR_SEED;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_steps  <= '0;
      r_error  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE) r_lfsr <= {r_lfsr[14:0], w_fb};
      case (r_state)
        S_IDLE: if (start) begin
          r_cur   <= start_state;
          r_goal  <= goal_state;
          // Seeding r_next lets ADV end a start==goal episode after one busy cycle.
          r_next  <= start_state;
          r_steps <= '0;
          r_error <= 1'b0;
          r_busy  <= 1'b1;
          r_idx   <= '0;
        end
        S_SEL, S_MAX: begin
          // Strict greater-than keeps the lower action index on ties.
          if (r_idx == 2'd0 || w_q > r_best) begin
            r_best   <= w_q;
            r_best_a <= r_idx;
          end
          r_idx <= w_scan_last ? 2'd0 : r_idx + 2'd1;
        end
        S_DEC: r_action <= w_explore ? r_lfsr[9:8] : r_best_a;
        S_ENV: if (env_ack) begin
          r_next   <= env_next_state;
          r_reward <= env_reward;
          if (w_bad_next) begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        S_UPD: if (upd_done) r_steps <= r_steps + 8'd1;
        S_ADV: begin
          if (w_at_end) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end else begin
            r_cur <= r_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign q_rd_state   = (r_state == S_MAX) ? r_next : r_cur;
  assign q_rd_action  = {2'b00, r_idx};
  assign env_req      = (r_state == S_ENV);
  assign env_state    = r_cur;
  assign env_action   = {2'b00, r_action};
  assign upd_go       = (r_state == S_UPD);
  assign upd_state    = r_cur;
  assign upd_action   = {2'b00, r_action};
  assign upd_max_q    = r_best;
  assign upd_reward   = r_reward;
  assign busy         = r_busy;
  assign episode_done = r_done;
  assign step_count   = r_steps;
  assign error        = r_error;
  assign dbg_state    = r_state;

endmodule
